cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : T-state sequencer for the 8-bit computer. Issues one control
//               state per clock from a (step, opcode-class) table, with stall,
//               sticky halt, an instruction-done strobe and an optional early
//               end of instruction (macro SEQ_EARLY_END_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int INSTR_W = 8,
    parameter int OPC_W   = 8,
    parameter int STATE_W = 8,
    parameter int MAX_T   = 8,
    parameter int CYC_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    output logic [STATE_W-1:0] state,
    output logic [CYC_W-1:0]   cycle,
    output logic [OPC_W-1:0]   opcode,
    output logic               halted,
    output logic               instr_done
);

    // Shared control-state encodings
    localparam logic [STATE_W-1:0] STATE_NEXT       = STATE_W'(8'h01);
    localparam logic [STATE_W-1:0] STATE_FETCH_PC   = STATE_W'(8'h02);
    localparam logic [STATE_W-1:0] STATE_FETCH_INST = STATE_W'(8'h03);
    localparam logic [STATE_W-1:0] STATE_HALT       = STATE_W'(8'h04);
    localparam logic [STATE_W-1:0] STATE_SET_REG    = STATE_W'(8'h05);
    localparam logic [STATE_W-1:0] STATE_MOV_FETCH  = STATE_W'(8'h06);
    localparam logic [STATE_W-1:0] STATE_MOV_LOAD   = STATE_W'(8'h07);
    localparam logic [STATE_W-1:0] STATE_MOV_STORE  = STATE_W'(8'h08);
    localparam logic [STATE_W-1:0] STATE_ALU_EXEC   = STATE_W'(8'h09);
    localparam logic [STATE_W-1:0] STATE_ALU_STORE  = STATE_W'(8'h0A);
    localparam logic [STATE_W-1:0] STATE_FETCH_SP   = STATE_W'(8'h0B);
    localparam logic [STATE_W-1:0] STATE_PC_STORE   = STATE_W'(8'h0C);
    localparam logic [STATE_W-1:0] STATE_TMP_JUMP   = STATE_W'(8'h0D);
    localparam logic [STATE_W-1:0] STATE_INC_SP     = STATE_W'(8'h0E);
    localparam logic [STATE_W-1:0] STATE_DEC_SP     = STATE_W'(8'h0F);
    localparam logic [STATE_W-1:0] STATE_REG_STORE  = STATE_W'(8'h10);
    localparam logic [STATE_W-1:0] STATE_IO_IN      = STATE_W'(8'h11);
    localparam logic [STATE_W-1:0] STATE_IO_OUT     = STATE_W'(8'h12);
    localparam logic [STATE_W-1:0] STATE_JUMP       = STATE_W'(8'h13);

    // Opcode classes (pattern-decoded classes plus pass-through opcodes)
    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_CMP  = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8'h10);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h18);
    localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(8'h20);
    localparam logic [OPC_W-1:0] OP_POP  = OPC_W'(8'h28);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(8'h40);
    localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(8'h80);

    // Instruction-byte patterns; low bits carry register/operand fields
    localparam logic [7:0] PATTERN_LDI  = 8'b00010???;
    localparam logic [7:0] PATTERN_JMP  = 8'b00011???;
    localparam logic [7:0] PATTERN_PUSH = 8'b00100???;
    localparam logic [7:0] PATTERN_POP  = 8'b00101???;
    localparam logic [7:0] PATTERN_MOV  = 8'b01??????;
    localparam logic [7:0] PATTERN_ALU  = 8'b10??????;

    // Step indices, 0 = T1; kept 32-bit so small CYC_W never aliases steps
    localparam logic [31:0] T1 = 32'd0;
    localparam logic [31:0] T2 = 32'd1;
    localparam logic [31:0] T3 = 32'd2;
    localparam logic [31:0] T4 = 32'd3;
    localparam logic [31:0] T5 = 32'd4;
    localparam logic [31:0] T6 = 32'd5;
    localparam logic [31:0] T7 = 32'd6;

    // Common width wide enough for the instruction, the opcode and the 8-bit patterns
    localparam int WIDE = (INSTR_W > OPC_W) ? ((INSTR_W > 8) ? INSTR_W : 8)
                                            : ((OPC_W > 8) ? OPC_W : 8);

    logic [WIDE-1:0]    w_instr_wide;
    logic [31:0]        w_step;
    logic [OPC_W-1:0]   w_opcode;
    logic [STATE_W-1:0] w_state;
    logic               w_last;
    logic               w_end;
    logic               w_halt_now;

    logic [STATE_W-1:0] r_state;
    logic [CYC_W-1:0]   r_cycle;
    logic [OPC_W-1:0]   r_opcode;
    logic               r_halted;
    logic               r_instr_done;

    assign w_instr_wide = WIDE'(instruction);
    assign w_step       = 32'(r_cycle);

    // Opcode-class decode; unmatched instructions pass through resized
    always_comb begin
        w_opcode = w_instr_wide[OPC_W-1:0];
        casez (w_instr_wide[7:0])
            PATTERN_LDI:  w_opcode = OP_LDI;
            PATTERN_JMP:  w_opcode = OP_JMP;
            PATTERN_PUSH: w_opcode = OP_PUSH;
            PATTERN_POP:  w_opcode = OP_POP;
            PATTERN_MOV:  w_opcode = OP_MOV;
            PATTERN_ALU:  w_opcode = OP_ALU;
            default:      ;
        endcase
    end

    // Step table: fetch in T1/T2, per-class micro-ops in T3..T7, NEXT otherwise
    always_comb begin
        w_state = STATE_NEXT;
        if (w_step == T1) begin
            w_state = STATE_FETCH_PC;
        end else if (w_step == T2) begin
            w_state = STATE_FETCH_INST;
        end else if (w_step <= T7) begin
            case (w_opcode)
                OP_HLT: if (w_step == T3) w_state = STATE_HALT;
                OP_IN:  if (w_step == T3) w_state = STATE_IO_IN;
                OP_OUT: if (w_step == T3) w_state = STATE_IO_OUT;
                OP_MOV: case (w_step)
                    T3:      w_state = STATE_MOV_FETCH;
                    T4:      w_state = STATE_MOV_LOAD;
                    T5:      w_state = STATE_MOV_STORE;
                    default: ;
                endcase
                OP_ALU, OP_CMP: case (w_step)
                    T3:      w_state = STATE_ALU_EXEC;
                    T4:      w_state = STATE_ALU_STORE;
                    default: ;
                endcase
                OP_RET: case (w_step)
                    T3:      w_state = STATE_INC_SP;
                    T4:      w_state = STATE_FETCH_SP;
                    T5:      w_state = STATE_TMP_JUMP;
                    default: ;
                endcase
                OP_POP: case (w_step)
                    T3:      w_state = STATE_INC_SP;
                    T4:      w_state = STATE_FETCH_SP;
                    T5:      w_state = STATE_SET_REG;
                    default: ;
                endcase
                OP_PUSH: case (w_step)
                    T3:      w_state = STATE_FETCH_SP;
                    T4:      w_state = STATE_REG_STORE;
                    T5:      w_state = STATE_DEC_SP;
                    default: ;
                endcase
                OP_CALL: case (w_step)
                    T3:      w_state = STATE_FETCH_PC;
                    T4:      w_state = STATE_SET_REG;
                    T5:      w_state = STATE_FETCH_SP;
                    T6:      w_state = STATE_PC_STORE;
                    T7:      w_state = STATE_TMP_JUMP;
                    default: ;
                endcase
                OP_LDI: case (w_step)
                    T3:      w_state = STATE_FETCH_PC;
                    T4:      w_state = STATE_SET_REG;
                    default: ;
                endcase
                OP_JMP: case (w_step)
                    T3:      w_state = STATE_FETCH_PC;
                    T4:      w_state = STATE_JUMP;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

    assign w_last     = (r_cycle == CYC_W'(MAX_T - 1));
    assign w_halt_now = (w_state == STATE_HALT);

`ifdef SEQ_EARLY_END_EN
    // An idle slot from T3 onward closes the instruction immediately
    assign w_end = w_last || ((w_step >= T3) && (w_state == STATE_NEXT));
`else
    // Every instruction runs the full MAX_T steps
    assign w_end = w_last;
`endif

    // Step counter, registered outputs, sticky halt and done strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= '0;
            r_cycle      <= '0;
            r_opcode     <= '0;
            r_halted     <= 1'b0;
            r_instr_done <= 1'b0;
        end else if (!r_halted) begin
            if (stall) begin
                r_instr_done <= 1'b0;
            end else begin
                r_state      <= w_state;
                r_opcode     <= w_opcode;
                r_cycle      <= w_end ? '0 : (r_cycle + CYC_W'(1));
                r_instr_done <= w_end && !w_halt_now;
                if (w_halt_now) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign state      = r_state;
    assign cycle      = r_cycle;
    assign opcode     = r_opcode;
    assign halted     = r_halted;
    assign instr_done = r_instr_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. Two instances
//               (MAX_T=8 and MAX_T=12) share stimulus; a step-list reference
//               model predicts every output, plus literal scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam logic [7:0] S_NEXT = 8'h01, S_FP = 8'h02, S_FI = 8'h03, S_HALT = 8'h04,
                           S_SETR = 8'h05, S_MOVF = 8'h06, S_MOVL = 8'h07, S_MOVS = 8'h08,
                           S_ALUE = 8'h09, S_ALUS = 8'h0A, S_FSP = 8'h0B, S_PCST = 8'h0C,
                           S_TJMP = 8'h0D, S_INCSP = 8'h0E, S_DECSP = 8'h0F, S_RST = 8'h10,
                           S_IN = 8'h11, S_OUT = 8'h12, S_JUMP = 8'h13;

    localparam logic [7:0] I_HLT = 8'h01, I_CMP = 8'h02, I_OUT = 8'h04, I_IN = 8'h05,
                           I_CALL = 8'h06, I_RET = 8'h07, I_LDI = 8'h12, I_JMP = 8'h1D,
                           I_PUSH = 8'h21, I_POP = 8'h2E, I_MOV = 8'h4B, I_ALU = 8'h9C;

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] instruction;
    logic       stall;

    logic [7:0] st8, op8, st12, op12;
    logic [3:0] cy8, cy12;
    logic       h8, d8, h12, d12;

    int n_vec;
    int n_err;

    // Reference model state, index 0 = MAX_T 8, index 1 = MAX_T 12
    int         maxt[2] = '{8, 12};
    int         m_cyc[2];
    logic [7:0] m_st[2];
    logic [7:0] m_op[2];
    bit         m_halt[2];
    bit         m_done[2];

    cpu_sequencer #(.INSTR_W(8), .OPC_W(8), .STATE_W(8), .MAX_T(8), .CYC_W(4)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .stall(stall),
        .state(st8), .cycle(cy8), .opcode(op8), .halted(h8), .instr_done(d8)
    );

    cpu_sequencer #(.INSTR_W(8), .OPC_W(8), .STATE_W(8), .MAX_T(12), .CYC_W(4)) u_dut12 (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .stall(stall),
        .state(st12), .cycle(cy12), .opcode(op12), .halted(h12), .instr_done(d12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Opcode class from instruction bit fields
    function automatic logic [7:0] ref_decode(input logic [7:0] ins);
        if (ins[7:6] == 2'b01)      return 8'h40;
        if (ins[7:6] == 2'b10)      return 8'h80;
        if (ins[7:3] == 5'b00010)   return 8'h10;
        if (ins[7:3] == 5'b00011)   return 8'h18;
        if (ins[7:3] == 5'b00100)   return 8'h20;
        if (ins[7:3] == 5'b00101)   return 8'h28;
        return ins;
    endfunction

    // Issued state for a step index (0 = T1) from per-class micro-op lists
    function automatic logic [7:0] ref_state(input int step, input logic [7:0] op);
        logic [7:0] seq[5];
        seq = '{S_NEXT, S_NEXT, S_NEXT, S_NEXT, S_NEXT};
        if (step == 0) return S_FP;
        if (step == 1) return S_FI;
        case (op)
            8'h01: seq = '{S_HALT, S_NEXT, S_NEXT, S_NEXT, S_NEXT};
            8'h04: seq = '{S_OUT,  S_NEXT, S_NEXT, S_NEXT, S_NEXT};
            8'h05: seq = '{S_IN,   S_NEXT, S_NEXT, S_NEXT, S_NEXT};
            8'h40: seq = '{S_MOVF, S_MOVL, S_MOVS, S_NEXT, S_NEXT};
            8'h80, 8'h02: seq = '{S_ALUE, S_ALUS, S_NEXT, S_NEXT, S_NEXT};
            8'h07: seq = '{S_INCSP, S_FSP, S_TJMP, S_NEXT, S_NEXT};
            8'h28: seq = '{S_INCSP, S_FSP, S_SETR, S_NEXT, S_NEXT};
            8'h20: seq = '{S_FSP, S_RST, S_DECSP, S_NEXT, S_NEXT};
            8'h06: seq = '{S_FP, S_SETR, S_FSP, S_PCST, S_TJMP};
            8'h10: seq = '{S_FP, S_SETR, S_NEXT, S_NEXT, S_NEXT};
            8'h18: seq = '{S_FP, S_JUMP, S_NEXT, S_NEXT, S_NEXT};
            default: ;
        endcase
        if (step <= 6) return seq[step-2];
        return S_NEXT;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_st[i] = 8'h00; m_op[i] = 8'h00; m_halt[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] s;
        logic [7:0] d;
        bit         fin;
        for (int i = 0; i < 2; i++) begin
            if (m_halt[i]) continue;
            if (stall) begin
                m_done[i] = 1'b0;
            end else begin
                d   = ref_decode(instruction);
                s   = ref_state(m_cyc[i], d);
                fin = (m_cyc[i] == maxt[i] - 1) || (EARLY && m_cyc[i] >= 2 && s == S_NEXT);
                m_st[i]   = s;
                m_op[i]   = d;
                m_cyc[i]  = fin ? 0 : m_cyc[i] + 1;
                m_done[i] = fin && (s != S_HALT);
                if (s == S_HALT) m_halt[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("m8_state",  st8,  m_st[0]);
        check("m8_cycle",  cy8,  m_cyc[0]);
        check("m8_opcode", op8,  m_op[0]);
        check("m8_halted", h8,   m_halt[0]);
        check("m8_done",   d8,   m_done[0]);
        check("m12_state", st12, m_st[1]);
        check("m12_cycle", cy12, m_cyc[1]);
        check("m12_opcode", op12, m_op[1]);
        check("m12_halted", h12, m_halt[1]);
        check("m12_done",  d12,  m_done[1]);
    endtask

    // One active edge, then outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    // Asynchronous reset pulse inside the low clock phase
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_state", {st8, st12}, 16'h0);
        check("rst_cycle", {cy8, cy12}, 8'h0);
        check("rst_opcode", {op8, op12}, 16'h0);
        check("rst_flags", {h8, d8, h12, d12}, 4'h0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ldi_exp[4];
        logic [7:0] call_exp[7];
        logic [7:0] ilist[16];
        int         ldi_len;
        int         call_len;

        n_vec = 0;
        n_err = 0;
        ldi_exp  = '{S_FP, S_FI, S_FP, S_SETR};
        call_exp = '{S_FP, S_FI, S_FP, S_SETR, S_FSP, S_PCST, S_TJMP};
        ilist    = '{I_HLT, I_CMP, I_OUT, I_IN, I_CALL, I_RET, I_LDI, I_JMP,
                     I_PUSH, I_POP, I_MOV, I_ALU, 8'h00, 8'hC3, 8'h37, 8'h6F};
        ldi_len  = EARLY ? 5 : 8;
        call_len = EARLY ? 8 : 12;

        reset_n     = 1'b0;
        instruction = 8'h00;
        stall       = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // LDI through one full instruction and into the next fetch
        instruction = I_LDI;
        for (int k = 1; k <= ldi_len + 1; k++) begin
            tick();
            check("ldi_state", st8, (k <= 4) ? ldi_exp[k-1] : ((k == ldi_len + 1) ? S_FP : S_NEXT));
            check("ldi_done", d8, (k == ldi_len));
            if (k == ldi_len) check("ldi_wrap_cycle", cy8, 0);
        end

        // Stall after the T2 edge of a MOV, then reset between T4 and T5
        @(negedge clk);
        do_reset();
        instruction = I_MOV;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_state", st8, S_FI);
            check("stall_cycle", cy8, 2);
            check("stall_done", d8, 0);
        end
        stall = 1'b0;
        tick();
        check("unstall_state", st8, S_MOVF);
        tick();
        check("mov_t4_state", st8, S_MOVL);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mov_restart", st8, (k == 0) ? S_FP : ((k == 1) ? S_FI : S_MOVF));
        end

        // HLT freezes everything until reset
        @(negedge clk);
        do_reset();
        instruction = I_HLT;
        tick(); tick(); tick();
        check("hlt_state", st8, S_HALT);
        check("hlt_halted", h8, 1);
        check("hlt_cycle", cy8, 3);
        for (int k = 0; k < 10; k++) begin
            instruction = ilist[$urandom_range(0, 15)];
            stall       = $urandom_range(0, 1);
            tick();
            check("frz_state", st8, S_HALT);
            check("frz_cycle", cy8, 3);
            check("frz_halt_done", {h8, d8}, 2'b10);
        end
        stall = 1'b0;
        do_reset();

        // CALL on the MAX_T=12 instance
        instruction = I_CALL;
        for (int k = 1; k <= call_len; k++) begin
            tick();
            check("call12_state", st12, (k <= 7) ? call_exp[k-1] : S_NEXT);
            check("call12_done", d12, (k == call_len));
        end
        check("call12_wrap_cycle", cy12, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 3) == 0) instruction = 8'($urandom);
                else                           instruction = ilist[$urandom_range(0, 15)];
            end
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) do_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
